// File: rtl/idli_pkg.sv
// Shared types and constants for the idli serial quad-I/O memory master.
package idli_pkg;

    typedef enum logic {
        SQI_MODE_IN  = 1'b0,
        SQI_MODE_OUT = 1'b1
    } sqi_mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        DUMMY = 3'd3,
        DATA  = 3'd4,
        DONE  = 3'd5
    } sqi_state_t;

    localparam logic [7:0] SQI_CMD_READ  = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

    // Counter must index the longest phase; the command phase is always 2 nibbles.
    function automatic int sqi_cnt_width(input int addr_n, input int data_n, input int dummy_n);
        int mx;
        mx = 2;
        if (addr_n > mx) mx = addr_n;
        if (data_n > mx) mx = data_n;
        if (dummy_n > mx) mx = dummy_n;
        return $clog2(mx);
    endfunction

endpackage

// File: rtl/idli_sqi_sreg_m.sv
// Nibble-wide shift register: parallel load, shifts toward the MSB end taking a
// new nibble in at the LSB end, so the head nibble leaves first.
module idli_sqi_sreg_m #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [4*NIBBLES-1:0] load_val,
    input  logic                 shift,
    input  logic [3:0]           shift_in,
    output logic [4*NIBBLES-1:0] value
);

    logic [4*NIBBLES-1:0] shifted;

    generate
        if (NIBBLES > 1) begin : g_multi
            assign shifted = {value[4*NIBBLES-5:0], shift_in};
        end else begin : g_single
            assign shifted = shift_in;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (shift) begin
            value <= shifted;
        end
    end

endmodule

// File: rtl/idli_sqi_m.sv
// Serial quad-I/O memory master: one request in, command/address/dummy/data
// nibbles out over a 4-bit pad, one-cycle completion pulse back.
module idli_sqi_m
    import idli_pkg::*;
#(
    parameter int ADDR_NIBBLES  = 4,
    parameter int DATA_NIBBLES  = 4,
    parameter int DUMMY_NIBBLES = 2
) (
    input  logic                      i_sqi_gck,
    input  logic                      i_sqi_rst,
    input  logic                      i_sqi_req_vld,
    output logic                      o_sqi_req_rdy,
    input  logic                      i_sqi_req_wr,
    input  logic [4*ADDR_NIBBLES-1:0] i_sqi_req_addr,
    input  logic [4*DATA_NIBBLES-1:0] i_sqi_req_wdata,
    output logic                      o_sqi_rsp_vld,
    output logic [4*DATA_NIBBLES-1:0] o_sqi_rsp_rdata,
    output logic                      o_sqi_sck,
    output logic                      o_sqi_cs,
    output sqi_mode_t                 o_sqi_mode,
    output logic [3:0]                o_sqi_data,
    input  logic [3:0]                i_sqi_data
);

    localparam int AC_W       = 4 * (ADDR_NIBBLES + 2);
    localparam int DW         = 4 * DATA_NIBBLES;
    localparam int CW         = sqi_cnt_width(ADDR_NIBBLES, DATA_NIBBLES, DUMMY_NIBBLES);
    localparam int DUMMY_LAST = (DUMMY_NIBBLES > 0) ? DUMMY_NIBBLES - 1 : 0;

    sqi_state_t    state, state_nxt;
    logic          ph;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last_idx;
    logic          wr_q;
    logic [DW-1:0] rdata_q;
    logic          accept, active, nib_end, last_nib;
    logic [AC_W-1:0] ac_value;
    logic [DW-1:0]   dat_value;
    logic [3:0]      ac_head, dat_head;

    // Request handshake: ready only while idle and out of reset; accept = vld & rdy.
    assign o_sqi_req_rdy = (state == IDLE) && !i_sqi_rst;
    assign accept        = i_sqi_req_vld && o_sqi_req_rdy;
    assign active        = state inside {CMD, ADDR, DUMMY, DATA};
    assign nib_end       = active && ph;
    assign last_nib      = nib_end && (cnt == last_idx);
    assign ac_head       = 4'(ac_value >> (AC_W - 4));
    assign dat_head      = 4'(dat_value >> (DW - 4));

    always_comb begin
        last_idx = '0;
        case (state)
            CMD:     last_idx = CW'(1);
            ADDR:    last_idx = CW'(ADDR_NIBBLES - 1);
            DUMMY:   last_idx = CW'(DUMMY_LAST);
            DATA:    last_idx = CW'(DATA_NIBBLES - 1);
            default: last_idx = '0;
        endcase
    end

    always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
        if (i_sqi_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        o_sqi_cs   = 1'b1;
        o_sqi_sck  = 1'b0;
        o_sqi_mode = SQI_MODE_IN;
        o_sqi_data = 4'h0;
        case (state)
            IDLE:  if (accept) state_nxt = CMD;
            CMD:   if (last_nib) state_nxt = ADDR;
            ADDR:  if (last_nib) state_nxt = (wr_q || DUMMY_NIBBLES == 0) ? DATA : DUMMY;
            DUMMY: if (last_nib) state_nxt = DATA;
            DATA:  if (last_nib) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (active) begin
            o_sqi_cs  = 1'b0;
            o_sqi_sck = ph;
        end
        if (state == CMD || state == ADDR) begin
            o_sqi_mode = SQI_MODE_OUT;
            o_sqi_data = ac_head;
        end else if (state == DATA && wr_q) begin
            o_sqi_mode = SQI_MODE_OUT;
            o_sqi_data = dat_head;
        end
    end

    always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
        if (i_sqi_rst) begin
            ph      <= 1'b0;
            cnt     <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) wr_q <= i_sqi_req_wr;
            ph <= active ? ~ph : 1'b0;
            if (nib_end) cnt <= last_nib ? '0 : cnt + CW'(1);
            if (state == DONE && !wr_q) rdata_q <= dat_value;
        end
    end

    // Command byte rides in front of the address so one register serves both phases.
    idli_sqi_sreg_m #(.NIBBLES(ADDR_NIBBLES + 2)) u_ac_sreg (
        .clk      (i_sqi_gck),
        .rst      (i_sqi_rst),
        .load     (accept),
        .load_val ({(i_sqi_req_wr ? SQI_CMD_WRITE : SQI_CMD_READ), i_sqi_req_addr}),
        .shift    (nib_end && (state == CMD || state == ADDR)),
        .shift_in (4'h0),
        .value    (ac_value)
    );

    idli_sqi_sreg_m #(.NIBBLES(DATA_NIBBLES)) u_dat_sreg (
        .clk      (i_sqi_gck),
        .rst      (i_sqi_rst),
        .load     (accept),
        .load_val (i_sqi_req_wdata),
        .shift    (nib_end && state == DATA),
        .shift_in (wr_q ? 4'h0 : i_sqi_data),
        .value    (dat_value)
    );

    assign o_sqi_rsp_vld   = (state == DONE);
    // The freshly assembled read word is visible during DONE, then held.
    assign o_sqi_rsp_rdata = (state == DONE && !wr_q) ? dat_value : rdata_q;

endmodule

// File: doc/idli_sqi_m.md
IDLI_SQI_M -- requirements
Module: idli_sqi_m

Interface
REQ-001 Parameters SHALL be: ADDR_NIBBLES, default 4, address nibbles sent per transaction (range 1..8).
REQ-002 DATA_NIBBLES, default 4, data nibbles per transaction (range 1..8).
REQ-003 DUMMY_NIBBLES, default 2, turnaround nibbles on reads only (range 0..4).
REQ-004 Ports SHALL be:
i_sqi_gck  in  1  clock; one clock; all state on rising edge
i_sqi_rst  in  1  reset, asynchronous, active-high
i_sqi_req_vld  in  1  request valid
o_sqi_req_rdy  out  1  request ready
i_sqi_req_wr  in  1  1=write, 0=read
i_sqi_req_addr  in  4*ADDR_NIBBLES  address
i_sqi_req_wdata  in  4*DATA_NIBBLES  write data
o_sqi_rsp_vld  out  1  one-cycle completion pulse
o_sqi_rsp_rdata  out  4*DATA_NIBBLES  read data
o_sqi_sck  out  1  memory serial clock
o_sqi_cs  out  1  chip select, active-low
o_sqi_mode  out  sqi_mode_t  pad direction (OUT/IN)
o_sqi_data  out  4  nibble to memory
i_sqi_data  in  4  nibble from memory

Function
REQ-005 States SHALL be IDLE, CMD, ADDR, DUMMY, DATA, DONE.
REQ-006 o_sqi_req_rdy SHALL be 1 only in IDLE; a request is accepted on an edge where vld and rdy are both 1.
REQ-007 On accept, wr, addr and wdata SHALL be latched; later changes to the request inputs SHALL have no effect.
REQ-008 Each nibble SHALL take two gck cycles: phase 0 with sck=0 and output data driven; phase 1 with sck=1.
REQ-009 i_sqi_data SHALL be sampled at the edge ending phase 1.
REQ-010 CMD SHALL send 2 nibbles, MSB first: 0x03 for a read, 0x02 for a write.
REQ-011 ADDR SHALL send ADDR_NIBBLES nibbles, MSB nibble first.
REQ-012 DUMMY SHALL last DUMMY_NIBBLES nibbles on reads and be skipped on writes.
REQ-013 DUMMY SHALL be skipped on reads when DUMMY_NIBBLES=0.
REQ-014 DATA SHALL transfer DATA_NIBBLES nibbles, MSB first: writes shift out latched wdata; reads shift sampled nibbles into rdata from the LSB end.
REQ-015 o_sqi_mode SHALL be OUT in CMD, ADDR and write DATA, and IN in DUMMY and read DATA.
REQ-016 o_sqi_data SHALL be 0 whenever mode is IN or the state is IDLE or DONE.
REQ-017 o_sqi_cs SHALL be 0 from the first CMD cycle through the last DATA cycle, and 1 in IDLE and DONE.
REQ-018 o_sqi_sck SHALL be 0 outside CMD, ADDR, DUMMY and DATA.
REQ-019 Latency: with accept on edge T, CMD starts at cycle T+1; with N the total nibbles, DONE is cycle T+1+2N and IDLE (rdy=1) is cycle T+2+2N.
REQ-020 o_sqi_rsp_vld SHALL be 1 for exactly the DONE cycle, for reads and writes alike.
REQ-021 o_sqi_rsp_rdata SHALL hold the last read result until the next read's DONE, and SHALL be unchanged by writes.
REQ-022 DONE SHALL force at least one cs-high cycle between back-to-back transactions; a request held valid is accepted in the first IDLE cycle.
REQ-023 The nibble counter SHALL be wide enough for max(2, ADDR_NIBBLES, DATA_NIBBLES, DUMMY_NIBBLES) with no wrap-around inside a phase.

Reset
REQ-024 Asserting i_sqi_rst at any time, including mid-transaction, SHALL immediately force IDLE with cs=1, sck=0, mode=IN, data=0, req_rdy=0, rsp_vld=0 and rdata=0.
REQ-025 An interrupted transaction SHALL produce no response.
REQ-026 req_rdy SHALL rise in the first cycle after reset deasserts.

Structure
REQ-027 idli_pkg SHALL hold sqi_mode_t (existing), a new sqi_state_t enum, and the constants SQI_CMD_READ=8'h03 and SQI_CMD_WRITE=8'h02.
REQ-028 One sub-module, idli_sqi_sreg_m, SHALL be used: a parametrised nibble shift register with load, shift-out and shift-in, instantiated for the address/command path and the data path.

Verification
REQ-029 Read, defaults, addr=0x1234, memory model returns A,B,C,D -> data 0,3,1,2,3,4 out; 2 IN dummy nibbles; rsp_vld at T+25 with rdata=0xABCD.
REQ-030 Write, defaults, addr=0x00F0, wdata=0xBEEF -> data 0,2,0,0,F,0,B,E,E,F out; no dummy; rsp_vld at T+21; rdata unchanged.
REQ-031 Back-to-back: req_vld held high for two reads -> exactly one DONE cycle with cs=1 between the transactions; second accept at T+26.
REQ-032 i_sqi_rst pulsed during read ADDR nibble 2 -> cs=1 and sck=0 in the same cycle; no rsp_vld; rdy=1 in the first cycle after release.
REQ-033 DUMMY_NIBBLES=0, ADDR_NIBBLES=6, DATA_NIBBLES=2, read addr=0xABCDEF -> DATA directly follows ADDR; rsp_vld at T+1+2*10.
REQ-034 Request inputs changed every cycle after accept -> transferred nibbles match the values latched at accept.
